snax_tcdm_responder: RTL and testbench
======================================

// Module: snax_tcdm_responder
// PURPOSE
//  Responder end of the SNAX TCDM port bundle: a banked, word-interleaved scratchpad that serves
//  NumPorts TCDM requesters (e.g. the GEMM accelerator's read/write ports) with per-bank
//  round-robin arbitration and a fixed 1-cycle response. Used as the accelerator-side memory
//  in standalone benches and as the reference TCDM model for accelerator integration.
// PARAMETERS
//  DataWidth    64        word width in bits; byte strobes are DataWidth/8 wide
//  AddrWidth    17        byte address width of tcdm_req_t.addr
//  NumPorts     16        number of requester ports
//  NumBanks     32        number of banks; power of two, >= 2
//  BankDepth    256       words per bank; power of two
//  tcdm_req_t   logic     request struct {q_valid, addr, write, amo, data, strb, user}
//  tcdm_rsp_t   logic     response struct {q_ready, p_valid, data}
// PORTS
//  clk_i          in   1                    clock; all state on rising edge
//  rst_i          in   1                    synchronous reset, active-high
//  tcdm_req_i     in   NumPorts x req_t     requests, one per port
//  tcdm_rsp_o     out  NumPorts x rsp_t     grant (q_ready) and response (p_valid, data)
// BEHAVIOUR
//  Address map: word offset = log2(DataWidth/8) bits (3 for 64b); bank = addr[3 +: log2(NumBanks)];
//   row = next log2(BankDepth) bits; bits above are ignored (addresses wrap modulo capacity).
//  Grant (combinational, same cycle): for each bank, among ports with q_valid and matching bank,
//   grant exactly one via round-robin starting at that bank's pointer; q_ready=1 only to winner.
//   Ports to different banks are all granted in the same cycle. q_ready=0 whenever q_valid=0.
//  Pointer: on a grant to port p, the bank's pointer becomes (p+1) mod NumPorts; unchanged otherwise.
//  Requester rule: a refused port holds its request stable until granted (bench checks this).
//  Write (write=1, amo=0): bytes with strb[b]=1 updated at the clock edge of the grant cycle;
//   strb=0 bytes unchanged.
//  Read (write=0, amo=0): data of the row as it was before this edge's write.
//  AMO (amo!=0): granted and answered like a read; memory not modified (unsupported, no error).
//  Response: every granted request (read, write, amo) yields p_valid=1 on its port exactly 1 cycle
//   after grant; data = read word for reads/amo, '0 for writes. p_valid held 1 cycle only, no
//   backpressure on the response path. A port may be granted every cycle (full throughput).
//  Same-bank collisions are serialised by the arbiter: a write and a read to the same address in
//   the same cycle resolve in grant order; same-cycle write hazards cannot occur (one grant per bank).
//  Reset (rst_i=1, also mid-operation): next edge clears all p_valid/response data to 0 and all
//   round-robin pointers to 0; any response in flight is dropped. While rst_i=1 all q_ready=0.
//   Memory contents are not reset (undefined until written).
//  Reset values of outputs: q_ready=0, p_valid=0, data='0 for all ports.
// STRUCTURE
//  snax_tcdm_pkg: bank/row index width functions, word-offset constant, default tcdm_req_t /
//   tcdm_rsp_t typedefs for DataWidth=64, AddrWidth=17.
//  Sub-module snax_rr_arbiter (NumReq parameter: req vector, pointer register, one-hot gnt,
//   sync active-high reset), instantiated once per bank; storage as a per-bank word array with
//   byte-enable write; response path is one register stage per port (valid, data).
// TESTING
//  1 Port0 write addr 0x40 data 0x1122334455667788 strb 0xFF, next cycle read 0x40 -> q_ready=1 both,
//    p_valid 1 cycle after each grant, read data 0x1122334455667788, write response data 0.
//  2 Partial strobe: write 0xFFFF..FF then strb 0x0F data 0 to 0x80, read -> 0xFFFFFFFF00000000.
//  3 Ports 0,3,5 all read bank 2 at once for 3 cycles (held) -> grants 0,3,5 in order, pointer ends 6,
//    p_valid on each port exactly 1 cycle after its grant.
//  4 16 ports read consecutive words 0x000..0x078 (distinct banks) -> all q_ready=1 same cycle,
//    all p_valid next cycle; repeated every cycle -> 100% throughput.
//  5 Wrap: write addr 0x10000 (beyond capacity, 32x256x8=0x10000) then read 0x0 -> same word returned.
//  6 Assert rst_i the cycle after a read grant -> no p_valid follows; pointers 0; q_ready=0 during reset.

Source files
------------

// File: rtl/snax_tcdm_pkg.sv
// Shared types and index-width helpers for the SNAX TCDM responder.
// Default request/response structs match a 64-bit data, 17-bit byte-address TCDM port.
package snax_tcdm_pkg;

    localparam int unsigned DefaultDataWidth = 64;
    localparam int unsigned DefaultAddrWidth = 17;
    localparam int unsigned WordOffset       = $clog2(DefaultDataWidth / 8);

    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bankIdxWidth(input int unsigned numBanks);
        return idxWidth(numBanks);
    endfunction

    function automatic int unsigned rowIdxWidth(input int unsigned bankDepth);
        return idxWidth(bankDepth);
    endfunction

    typedef struct packed {
        logic                          q_valid;
        logic [DefaultAddrWidth-1:0]   addr;
        logic                          write;
        logic [3:0]                    amo;
        logic [DefaultDataWidth-1:0]   data;
        logic [DefaultDataWidth/8-1:0] strb;
        logic                          user;
    } default_tcdm_req_t;

    typedef struct packed {
        logic                        q_ready;
        logic                        p_valid;
        logic [DefaultDataWidth-1:0] data;
    } default_tcdm_rsp_t;

endpackage

// File: rtl/snax_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves just past the winner whenever a grant is issued.
module snax_rr_arbiter
    import snax_tcdm_pkg::*;
#(
    parameter int unsigned NumReq = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NumReq-1:0] i_req,
    output logic [NumReq-1:0] o_gnt
);

    localparam int unsigned IdxW = idxWidth(NumReq);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_winner;
    logic            w_found;
    int unsigned     w_idx;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        o_gnt    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NumReq) begin
                w_idx = w_idx - NumReq;
            end
            if (!w_found && i_req[IdxW'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IdxW'(w_idx);
            end
        end
        if (w_found) begin
            o_gnt[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_winner == IdxW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
        end
    end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Banked, word-interleaved TCDM scratchpad: per-bank round-robin grant in the request cycle,
// byte-enable writes at that edge, and a registered response exactly one cycle later.
module snax_tcdm_responder
    import snax_tcdm_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 17,
    parameter int unsigned NumPorts  = 16,
    parameter int unsigned NumBanks  = 32,
    parameter int unsigned BankDepth = 256,
    parameter type tcdm_req_t = default_tcdm_req_t,
    parameter type tcdm_rsp_t = default_tcdm_rsp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  tcdm_req_t tcdm_req_i [NumPorts],
    output tcdm_rsp_t tcdm_rsp_o [NumPorts]
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = idxWidth(StrbW);
    localparam int unsigned BankW = bankIdxWidth(NumBanks);
    localparam int unsigned RowW  = rowIdxWidth(BankDepth);

    logic [AddrWidth-1:0] w_addr      [NumPorts];
    logic [BankW-1:0]     w_portBank  [NumPorts];
    logic [RowW-1:0]      w_portRow   [NumPorts];
    logic [NumPorts-1:0]  w_isWrite;
    logic [NumPorts-1:0]  w_qReady;
    logic [NumPorts-1:0]  w_bankGnt   [NumBanks];
    logic [DataWidth-1:0] w_bankRdata [NumBanks];
    logic [NumPorts-1:0]  r_pValid;
    logic [DataWidth-1:0] r_rspData   [NumPorts];

    // Address bits above bank and row are dropped, so addresses wrap modulo capacity.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_addr[p]     = tcdm_req_i[p].addr;
            w_portBank[p] = w_addr[p][OffW +: BankW];
            w_portRow[p]  = w_addr[p][OffW + BankW +: RowW];
            w_isWrite[p]  = tcdm_req_i[p].write && (tcdm_req_i[p].amo == '0);
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_qReady[p] = w_bankGnt[w_portBank[p]][p];
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [NumPorts-1:0]  w_req;
        logic [RowW-1:0]      w_selRow;
        logic [DataWidth-1:0] w_selData;
        logic [StrbW-1:0]     w_selStrb;
        logic                 w_selWe;
        logic [DataWidth-1:0] r_mem [BankDepth];

        always_comb begin
            w_req = '0;
            for (int p = 0; p < NumPorts; p++) begin
                w_req[p] = !rst_i && tcdm_req_i[p].q_valid && (w_portBank[p] == BankW'(b));
            end
        end

        snax_rr_arbiter #(
            .NumReq(NumPorts)
        ) u_arb (
            .i_clk(clk_i),
            .i_rst(rst_i),
            .i_req(w_req),
            .o_gnt(w_bankGnt[b])
        );

        always_comb begin
            w_selRow  = '0;
            w_selData = '0;
            w_selStrb = '0;
            w_selWe   = 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                if (w_bankGnt[b][p]) begin
                    w_selRow  = w_portRow[p];
                    w_selData = tcdm_req_i[p].data;
                    w_selStrb = tcdm_req_i[p].strb;
                    w_selWe   = w_isWrite[p];
                end
            end
        end

        // Storage is deliberately not reset; contents stay undefined until written.
        always_ff @(posedge clk_i) begin
            if (w_selWe) begin
                for (int i = 0; i < StrbW; i++) begin
                    if (w_selStrb[i]) begin
                        r_mem[w_selRow][i*8 +: 8] <= w_selData[i*8 +: 8];
                    end
                end
            end
        end

        assign w_bankRdata[b] = r_mem[w_selRow];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pValid <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                r_rspData[p] <= '0;
            end
        end else begin
            r_pValid <= w_qReady;
            for (int p = 0; p < NumPorts; p++) begin
                r_rspData[p] <= (w_qReady[p] && !w_isWrite[p]) ? w_bankRdata[w_portBank[p]] : '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            tcdm_rsp_o[p]         = '0;
            tcdm_rsp_o[p].q_ready = w_qReady[p];
            tcdm_rsp_o[p].p_valid = r_pValid[p];
            tcdm_rsp_o[p].data    = r_rspData[p];
        end
    end

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Bench for snax_tcdm_responder: directed scenarios plus held-request random traffic,
// compared against a word-array / per-bank-pointer reference model.
module tb_snax_tcdm_responder;
    import snax_tcdm_pkg::*;

    localparam int NP = 16;
    localparam int NB = 32;
    localparam int NW = 8192;

    logic clk = 1'b0;
    logic rst;
    default_tcdm_req_t req [NP];
    default_tcdm_rsp_t rsp [NP];

    always #5 clk = ~clk;

    snax_tcdm_responder dut (
        .clk_i(clk),
        .rst_i(rst),
        .tcdm_req_i(req),
        .tcdm_rsp_o(rsp)
    );

    int total = 0;
    int bad = 0;

    logic [63:0] mMem [NW];
    bit          mKnown [NW];
    int          mPtr [NB];
    bit          expReady [NP];
    bit          nextPv [NP];
    bit          expPv [NP];
    bit          nextKnown [NP];
    bit          expKnown [NP];
    logic [63:0] nextData [NP];
    logic [63:0] expData [NP];

    function automatic int wordOf(input logic [16:0] a);
        return (int'(a) / 8) % NW;
    endfunction

    task automatic clearReqs();
        for (int p = 0; p < NP; p++) begin
            req[p] = '0;
        end
    endtask

    task automatic setReq(input int p, input logic [16:0] a, input bit wr,
                          input logic [63:0] d, input logic [7:0] s, input logic [3:0] amo);
        req[p].q_valid = 1'b1;
        req[p].addr    = a;
        req[p].write   = wr;
        req[p].amo     = amo;
        req[p].data    = d;
        req[p].strb    = s;
        req[p].user    = 1'b0;
    endtask

    // Settles the combinational grant, then predicts grants, responses and memory after the edge.
    task automatic applyStimulus();
        int w;
        #1;
        for (int p = 0; p < NP; p++) begin
            expReady[p]  = 0;
            nextPv[p]    = 0;
            nextData[p]  = '0;
            nextKnown[p] = 1;
        end
        if (rst) begin
            for (int b = 0; b < NB; b++) mPtr[b] = 0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (mPtr[b] + k) % NP;
                    if (req[p].q_valid && (wordOf(req[p].addr) % NB == b)) begin
                        expReady[p] = 1;
                        nextPv[p]   = 1;
                        mPtr[b]     = (p + 1) % NP;
                        break;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (expReady[p] && !(req[p].write && req[p].amo == 0)) begin
                    w = wordOf(req[p].addr);
                    nextData[p]  = mMem[w];
                    nextKnown[p] = mKnown[w];
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (expReady[p] && req[p].write && req[p].amo == 0) begin
                    w = wordOf(req[p].addr);
                    for (int i = 0; i < 8; i++) begin
                        if (req[p].strb[i]) mMem[w][i*8 +: 8] = req[p].data[i*8 +: 8];
                    end
                    mKnown[w] = mKnown[w] || (req[p].strb == 8'hFF);
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            expPv[p]    = nextPv[p];
            expData[p]  = nextData[p];
            expKnown[p] = nextKnown[p];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) setReq(p, 17'(p * 8), 0, '0, 8'h00, 4'h0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rsp[p].q_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL reset_ready port=%0d got=%b want=0", p, rsp[p].q_ready);
                end
            end
            advance();
        end
        for (int p = 0; p < NP; p++) begin
            total++;
            if (rsp[p].p_valid !== 1'b0 || rsp[p].data !== 64'h0) begin
                bad++;
                $display("[TB] FAIL reset_rsp port=%0d got pv=%b data=%h want pv=0 data=0",
                         p, rsp[p].p_valid, rsp[p].data);
            end
        end
        rst = 1'b0;
        clearReqs();
    endtask

    task automatic test_write_read();
        setReq(0, 17'h40, 1, 64'h1122334455667788, 8'hFF, 4'h0);
        applyStimulus();
        total++;
        if (rsp[0].q_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_ready got=%b want=1", rsp[0].q_ready);
        end
        advance();
        total++;
        if (rsp[0].p_valid !== 1'b1 || rsp[0].data !== 64'h0) begin
            bad++; $display("[TB] FAIL wr_rsp got pv=%b data=%h want pv=1 data=0", rsp[0].p_valid, rsp[0].data);
        end
        setReq(0, 17'h40, 0, '0, 8'h00, 4'h0);
        applyStimulus();
        total++;
        if (rsp[0].q_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL rd_ready got=%b want=1", rsp[0].q_ready);
        end
        advance();
        total++;
        if (rsp[0].p_valid !== 1'b1 || rsp[0].data !== 64'h1122334455667788) begin
            bad++; $display("[TB] FAIL rd_rsp got pv=%b data=%h want pv=1 data=1122334455667788",
                            rsp[0].p_valid, rsp[0].data);
        end
        clearReqs();
        applyStimulus();
        advance();
        total++;
        if (rsp[0].p_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL pv_one_cycle got=%b want=0", rsp[0].p_valid);
        end
    endtask

    task automatic test_partial_strobe();
        setReq(1, 17'h80, 1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'h0);
        applyStimulus();
        advance();
        setReq(1, 17'h80, 1, 64'h0, 8'h0F, 4'h0);
        applyStimulus();
        advance();
        setReq(1, 17'h80, 0, '0, 8'h00, 4'h0);
        applyStimulus();
        advance();
        total++;
        if (rsp[1].p_valid !== 1'b1 || rsp[1].data !== 64'hFFFFFFFF00000000) begin
            bad++; $display("[TB] FAIL strobe got pv=%b data=%h want pv=1 data=ffffffff00000000",
                            rsp[1].p_valid, rsp[1].data);
        end
        clearReqs();
    endtask

    task automatic test_contention();
        int portsA[3] = '{0, 3, 5};
        int winA[3]   = '{0, 3, 5};
        int portsB[3] = '{5, 6, 7};
        int winB[3]   = '{6, 7, 5};
        for (int i = 0; i < 3; i++) setReq(portsA[i], 17'(32'h10 + i * 32'h100), 0, '0, 8'h00, 4'h0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rsp[portsA[i]].q_ready !== (portsA[i] == winA[c])) begin
                    bad++; $display("[TB] FAIL contend_ready cyc=%0d port=%0d got=%b want=%b",
                                    c, portsA[i], rsp[portsA[i]].q_ready, portsA[i] == winA[c]);
                end
            end
            advance();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rsp[portsA[i]].p_valid !== (portsA[i] == winA[c])) begin
                    bad++; $display("[TB] FAIL contend_pv cyc=%0d port=%0d got=%b want=%b",
                                    c, portsA[i], rsp[portsA[i]].p_valid, portsA[i] == winA[c]);
                end
            end
            req[winA[c]].q_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) setReq(portsB[i], 17'(32'h10 + i * 32'h100), 0, '0, 8'h00, 4'h0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rsp[portsB[i]].q_ready !== (portsB[i] == winB[c])) begin
                    bad++; $display("[TB] FAIL pointer_ready cyc=%0d port=%0d got=%b want=%b",
                                    c, portsB[i], rsp[portsB[i]].q_ready, portsB[i] == winB[c]);
                end
            end
            advance();
            req[winB[c]].q_valid = 1'b0;
        end
        clearReqs();
    endtask

    task automatic test_throughput();
        for (int p = 0; p < NP; p++) setReq(p, 17'(p * 8), 0, '0, 8'h00, 4'h0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rsp[p].q_ready !== 1'b1) begin
                    bad++; $display("[TB] FAIL tput_ready cyc=%0d port=%0d got=%b want=1", c, p, rsp[p].q_ready);
                end
            end
            advance();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rsp[p].p_valid !== 1'b1) begin
                    bad++; $display("[TB] FAIL tput_pv cyc=%0d port=%0d got=%b want=1", c, p, rsp[p].p_valid);
                end
            end
        end
        clearReqs();
    endtask

    task automatic test_wrap();
        setReq(4, 17'h10000, 1, 64'hA5A50F0F12345678, 8'hFF, 4'h0);
        applyStimulus();
        advance();
        setReq(4, 17'h00000, 0, '0, 8'h00, 4'h0);
        applyStimulus();
        advance();
        total++;
        if (rsp[4].p_valid !== 1'b1 || rsp[4].data !== 64'hA5A50F0F12345678) begin
            bad++; $display("[TB] FAIL wrap got pv=%b data=%h want pv=1 data=a5a50f0f12345678",
                            rsp[4].p_valid, rsp[4].data);
        end
        clearReqs();
    endtask

    task automatic test_reset_midflight();
        setReq(2, 17'h40, 0, '0, 8'h00, 4'h0);
        applyStimulus();
        total++;
        if (rsp[2].q_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_grant got=%b want=1", rsp[2].q_ready);
        end
        advance();
        rst = 1'b1;
        applyStimulus();
        total++;
        if (rsp[2].q_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_ready_in_reset got=%b want=0", rsp[2].q_ready);
        end
        advance();
        total++;
        if (rsp[2].p_valid !== 1'b0 || rsp[2].data !== 64'h0) begin
            bad++; $display("[TB] FAIL mid_rsp_cleared got pv=%b data=%h want pv=0 data=0", rsp[2].p_valid, rsp[2].data);
        end
        rst = 1'b0;
        clearReqs();
        applyStimulus();
        advance();
        total++;
        if (rsp[2].p_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_no_pv got=%b want=0", rsp[2].p_valid);
        end
        setReq(2, 17'h40, 0, '0, 8'h00, 4'h0);
        setReq(15, 17'h140, 0, '0, 8'h00, 4'h0);
        applyStimulus();
        total++;
        if (rsp[2].q_ready !== 1'b1 || rsp[15].q_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_ptr_zero got r2=%b r15=%b want r2=1 r15=0", rsp[2].q_ready, rsp[15].q_ready);
        end
        advance();
        req[2].q_valid = 1'b0;
        applyStimulus();
        advance();
        clearReqs();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic [16:0] a;
            for (int p = 0; p < NP; p++) begin
                if (!(req[p].q_valid && !expReady[p])) begin
                    if ($urandom_range(1, 0) == 1) begin
                        a = 17'(($urandom_range(2, 0) * NB + $urandom_range(3, 0)) * 8);
                        if ($urandom_range(7, 0) == 0) a[16] = 1'b1;
                        setReq(p, a, $urandom_range(1, 0) == 1, {$urandom, $urandom},
                               ($urandom_range(3, 0) != 0) ? 8'hFF : 8'($urandom),
                               ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'h0);
                    end else begin
                        req[p].q_valid = 1'b0;
                    end
                end
            end
            applyStimulus();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rsp[p].q_ready !== expReady[p]) begin
                    bad++; $display("[TB] FAIL rnd_ready cyc=%0d port=%0d got=%b want=%b", cyc, p, rsp[p].q_ready, expReady[p]);
                end
            end
            advance();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rsp[p].p_valid !== expPv[p]) begin
                    bad++; $display("[TB] FAIL rnd_pv cyc=%0d port=%0d got=%b want=%b", cyc, p, rsp[p].p_valid, expPv[p]);
                end
                if (expPv[p] && expKnown[p]) begin
                    total++;
                    if (rsp[p].data !== expData[p]) begin
                        bad++; $display("[TB] FAIL rnd_data cyc=%0d port=%0d got=%h want=%h", cyc, p, rsp[p].data, expData[p]);
                    end
                end
            end
        end
        clearReqs();
    endtask

    initial begin
        rst = 1'b1;
        clearReqs();
        for (int b = 0; b < NB; b++) mPtr[b] = 0;
        for (int w = 0; w < NW; w++) begin
            mKnown[w] = 0;
            mMem[w]   = '0;
        end
        for (int p = 0; p < NP; p++) begin
            expReady[p] = 0;
            expPv[p]    = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_contention();
        test_throughput();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
